// File: rtl/uni_serializer_if.sv
// Load/serial bundle between a parallel source, the serializer and the serial sink.
// Latency: n/a (wires only).
// Backpressure: load_valid/load_ready on the load side; sout_valid drops while hold is high.
interface uni_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             dir;
    logic             hold;
    logic             clr;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    // Source/controller side: offers words and steers the shifter.
    modport master (
        output din, load_valid, dir, hold, clr,
        input  load_ready, sout, sout_valid, busy, done
    );

    // Serializer side.
    modport slave (
        input  din, load_valid, dir, hold, clr,
        output load_ready, sout, sout_valid, busy, done
    );
endinterface

// File: rtl/uni_serializer.sv
// Parallel-in/serial-out transmitter, MSB- or LSB-first; optional even parity bit (UNI_SERIALIZER_PARITY_EN).
// Latency: first bit on sout the cycle after accept; done pulses in cycle WIDTH+1 (WIDTH+2 with parity).
// Backpressure: load_ready only in IDLE; hold freezes all shift state and drops sout_valid.
module uni_serializer #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    uni_serializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             dir_q,   dir_d;
    logic             sout_q,  sout_d;
    logic             done_q,  done_d;
`ifdef UNI_SERIALIZER_PARITY_EN
    logic             par_q,   par_d;
`endif
    logic             busy;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clr aborts, hold freezes, otherwise advance on accept / last bit.
    always_comb begin
        state_d = state_q;
        if (bus.clr) begin
            state_d = S_IDLE;
        end else if (!bus.hold) begin
            case (state_q)
                S_IDLE:   if (bus.load_valid) state_d = S_SHIFT;
`ifdef UNI_SERIALIZER_PARITY_EN
                S_SHIFT:  if (cnt_q == CW'(1)) state_d = S_PARITY;
`else
                S_SHIFT:  if (cnt_q == CW'(1)) state_d = S_IDLE;
`endif
                S_PARITY: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from the current state; sout_valid is live only while not stalled.
    always_comb begin
        busy           = (state_q != S_IDLE);
        bus.load_ready = rst && (state_q == S_IDLE);
        bus.busy       = busy;
        bus.sout_valid = busy && !bus.hold;
        bus.sout       = sout_q;
        bus.done       = done_q;
    end

    // Datapath next values: capture on accept, emit one bit per transfer edge.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
`ifdef UNI_SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        if (bus.clr) begin
            sout_d  = 1'b0;
            cnt_d   = '0;
            shreg_d = '0;
        end else if (!bus.hold) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.load_valid) begin
                        dir_d = bus.dir;
                        cnt_d = CW'(WIDTH);
`ifdef UNI_SERIALIZER_PARITY_EN
                        par_d = ^bus.din;
`endif
                        if (bus.dir) begin
                            sout_d  = bus.din[0];
                            shreg_d = bus.din >> 1;
                        end else begin
                            sout_d  = bus.din[WIDTH-1];
                            shreg_d = bus.din << 1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (cnt_q == CW'(1)) begin
                        cnt_d   = '0;
                        shreg_d = '0;
`ifdef UNI_SERIALIZER_PARITY_EN
                        sout_d  = par_q;
`else
                        sout_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                        if (dir_q) begin
                            sout_d  = shreg_q[0];
                            shreg_d = shreg_q >> 1;
                        end else begin
                            sout_d  = shreg_q[WIDTH-1];
                            shreg_d = shreg_q << 1;
                        end
                    end
                end
                S_PARITY: begin
                    sout_d = 1'b0;
                    done_d = 1'b1;
                end
                default: begin
                    sout_d = 1'b0;
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UNI_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
`ifdef UNI_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_uni_serializer.sv
// Self-checking bench for uni_serializer: queue-based stream model plus directed frames.
// Latency: n/a.
// Backpressure: exercises hold, clr, ignored loads and mid-frame reset.
`timescale 1ns/1ps
module tb_uni_serializer;
    localparam int W = 4;
`ifdef UNI_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    uni_serializer_if #(.WIDTH(W)) bus();

    uni_serializer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: bits still owed on the wire for the current frame, in wire order.
    logic exp_q[$];
    logic exp_done = 1'b0;

    // Advance the model on every clock edge (and on async reset).
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            exp_done = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (bus.clr) begin
                exp_q.delete();
            end else if (bus.hold) begin
                // stalled: nothing moves
            end else if (exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) exp_done = 1'b1;
            end else if (bus.load_valid) begin
                for (int i = 0; i < W; i++)
                    exp_q.push_back(bus.dir ? bus.din[i] : bus.din[W-1-i]);
                if (PAR != 0) exp_q.push_back(^bus.din);
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("sout",       {31'd0, bus.sout},       {31'd0, (exp_q.size() > 0) ? exp_q[0] : 1'b0});
        chk("sout_valid", {31'd0, bus.sout_valid}, {31'd0, (exp_q.size() > 0) && !bus.hold});
        chk("busy",       {31'd0, bus.busy},       {31'd0, exp_q.size() > 0});
        chk("load_ready", {31'd0, bus.load_ready}, {31'd0, rst && (exp_q.size() == 0)});
        chk("done",       {31'd0, bus.done},       {31'd0, exp_done});
    end

    // One frame: accept, optionally stall for hold_len cycles from cycle hold_at, collect wire bits.
    task automatic run_frame(input logic [W-1:0] d, input logic dr, input int hold_at, input int hold_len,
                             output logic [7:0] bits, output int done_lat, output int busy_cyc);
        bits = '0;
        done_lat = -1;
        busy_cyc = 0;
        @(posedge clk); #2;
        bus.din = d; bus.dir = dr; bus.load_valid = 1'b1;
        @(posedge clk); #2;
        bus.load_valid = 1'b0;
        bus.dir = ~dr;
        for (int k = 1; k <= 40; k++) begin
            bus.hold = (k >= hold_at) && (k < hold_at + hold_len);
            @(negedge clk);
            if (bus.busy) busy_cyc++;
            if (bus.sout_valid) bits = {bits[6:0], bus.sout};
            if (bus.done) begin
                done_lat = k;
                break;
            end
            @(posedge clk); #2;
        end
        bus.hold = 1'b0;
    endtask

    logic [7:0] bits;
    int lat, bc;

    initial begin
        bus.din = '0; bus.dir = 1'b0; bus.load_valid = 1'b0; bus.hold = 1'b0; bus.clr = 1'b0;

        // Reset with clock running.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sout", bus.sout, 0);
        chk("rst_sout_valid", bus.sout_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", bus.load_ready, 1);

        // MSB-first 1011.
        run_frame(4'b1011, 1'b0, 0, 0, bits, lat, bc);
        chk("msb_bits", bits, PAR ? 8'b10111 : 8'b1011);
        chk("msb_done_lat", lat, W + 1 + PAR);
        chk("msb_ready_at_done", bus.load_ready, 1);
        chk("msb_busy_cycles", bc, W + PAR);

        // LSB-first 1011, dir flipped mid-frame.
        run_frame(4'b1011, 1'b1, 0, 0, bits, lat, bc);
        chk("lsb_bits", bits, PAR ? 8'b11011 : 8'b1101);
        chk("lsb_busy_cycles", bc, W + PAR);
        chk("lsb_done_lat", lat, W + 1 + PAR);

        // Hold for 3 cycles while the second bit is on the wire.
        run_frame(4'b0110, 1'b0, 2, 3, bits, lat, bc);
        chk("hold_bits", bits, PAR ? 8'b01100 : 8'b0110);
        chk("hold_done_lat", lat, W + 1 + PAR + 3);

        // Parity-zero word.
        run_frame(4'b0011, 1'b0, 0, 0, bits, lat, bc);
        chk("p0_bits", bits, PAR ? 8'b00110 : 8'b0011);
        chk("p0_done_lat", lat, W + 1 + PAR);

        // Clear after two bits; a load offered mid-frame is ignored.
        @(posedge clk); #2;
        bus.din = 4'b1111; bus.dir = 1'b0; bus.load_valid = 1'b1;
        @(posedge clk); #2;
        bus.load_valid = 1'b0;
        @(posedge clk); #2;
        bus.din = 4'b0001; bus.load_valid = 1'b1;
        @(negedge clk);
        chk("clr_ready_in_shift", bus.load_ready, 0);
        @(posedge clk); #2;
        bus.load_valid = 1'b0; bus.clr = 1'b1;
        @(posedge clk); #2;
        bus.clr = 1'b0;
        @(negedge clk);
        chk("clr_busy", bus.busy, 0);
        chk("clr_sout", bus.sout, 0);
        chk("clr_done", bus.done, 0);
        repeat (3) begin
            @(negedge clk);
            chk("clr_no_done", bus.done, 0);
            chk("clr_no_accept", bus.busy, 0);
        end

        // clr in IDLE blocks an offered load.
        @(posedge clk); #2;
        bus.din = 4'b1010; bus.load_valid = 1'b1; bus.clr = 1'b1;
        @(posedge clk); #2;
        bus.load_valid = 1'b0; bus.clr = 1'b0;
        @(negedge clk);
        chk("clr_idle_block", bus.busy, 0);

        // Async reset mid-frame: immediate abort, no done.
        @(posedge clk); #2;
        bus.din = 4'b1001; bus.dir = 1'b0; bus.load_valid = 1'b1;
        @(posedge clk); #2;
        bus.load_valid = 1'b0;
        @(posedge clk); #4;
        rst = 1'b0;
        #2;
        chk("arst_busy", bus.busy, 0);
        chk("arst_sout", bus.sout, 0);
        chk("arst_sout_valid", bus.sout_valid, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("arst_no_done", bus.done, 0);
        end

        // Recovery frame, LSB-first 0101.
        run_frame(4'b0101, 1'b1, 0, 0, bits, lat, bc);
        chk("rec_bits", bits, PAR ? 8'b10100 : 8'b1010);
        chk("rec_done_lat", lat, W + 1 + PAR);

        @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uni_serializer.md
Name: uni_serializer

Overview:
- Parallel-in, serial-out transmitter: the counterpart of the universal serial-in/parallel-out shift register.
- Accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per accepted cycle, MSB-first or LSB-first.
- Supports hold (stall) and synchronous clear, and pulses done at end of frame.
- Sits between a parallel data source and a serial link or a receiving shift register.

Parameters:
- WIDTH, 4, data word width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word to transmit.
- load_valid  input  1  source offers din.
- load_ready  output  1  block can accept a word (high only in IDLE).
- dir  input  1  0 = MSB-first (left shift), 1 = LSB-first (right shift); sampled at accept.
- hold  input  1  stall; freezes all shift state.
- clr  input  1  synchronous abort to IDLE.
- sout  output  1  serial data, registered.
- sout_valid  output  1  sout is a live bit this cycle.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse after last bit transferred.

Behaviour:
- Reset (rst=0, async) clears all state: IDLE, shift reg 0, bit counter 0, sout=0, sout_valid=0, busy=0, done=0, load_ready=1 once rst releases. Reset mid-frame aborts the frame with no done.
- Input priority: rst > clr > hold > shift/load.
- States: IDLE, SHIFT (plus PARITY when the optional feature is enabled).
- IDLE:
  - load_ready=1, busy=0, sout=0.
  - Accept on the edge where load_valid & load_ready. At that edge: capture dir; sout <= first bit (din[WIDTH-1] if dir=0, din[0] if dir=1); shift reg <= remaining bits; counter <= WIDTH; go SHIFT.
- SHIFT:
  - busy=1, load_ready=0; load_valid is ignored.
  - sout_valid = busy & ~hold (combinational). A bit transfers on every rising edge where sout_valid=1.
  - On a transfer edge: sout <= next bit, counter decrements.
  - On the transfer edge with counter=1 (last bit): state <= IDLE, sout <= 0, done <= 1.
- hold=1: sout, shift reg, counter and state frozen; sout_valid=0. No bit is lost or duplicated.
- done:
  - Registered; high for exactly one cycle, the first IDLE cycle after the frame.
  - load_ready is also high in that cycle, so a new word may be accepted there. Minimum frame spacing is one idle cycle.
- clr=1 on any edge: next state IDLE; sout=0; counter=0; done stays 0. clr in IDLE with load_valid=1 blocks the accept.
- Latency (no hold): first bit visible the cycle after the accept edge. Bit k is visible in cycle k+1. done is high in cycle WIDTH+1.
- dir change mid-frame has no effect; the value latched at accept is used.

Optional Feature:
- Macro: UNI_SERIALIZER_PARITY_EN.
- Defined:
  - After the last data bit, a PARITY state transmits one extra bit equal to the XOR of the captured word (even parity), with the same sout_valid/hold/clr rules.
  - done pulses after the parity bit transfers.
  - Frame length = WIDTH+1.
- Undefined: no PARITY state; frame length = WIDTH; done follows the last data bit.

Test Plan:
- Reset: rst=0 with clk running → sout=0, sout_valid=0, busy=0, done=0. Release rst → load_ready=1.
- MSB-first: din=4'b1011, dir=0, load_valid for one cycle, hold=0 → sout=1,0,1,1 on 4 consecutive sout_valid cycles; done=1 for one cycle afterwards; load_ready=1 in that cycle.
- LSB-first: din=4'b1011, dir=1 → sout=1,1,0,1; busy high exactly 4 cycles.
- Hold: MSB-first din=4'b0110, assert hold for 3 cycles while the second bit is on sout → sout stays 1 and sout_valid=0 for those cycles; transferred sequence still 0,1,1,0; done 3 cycles later than without hold.
- Clear and ignored load: din=4'b1111, assert clr after 2 bits transferred → next cycle busy=0, sout=0, no done pulse. A load_valid with din=4'b0001 during SHIFT is not accepted (load_ready=0).
- With UNI_SERIALIZER_PARITY_EN: din=4'b1011, dir=0 → sout=1,0,1,1, then parity bit 1; done after the 5th bit. din=4'b0011 → parity bit 0.
